pixel_config_array: RTL and testbench
=====================================

// Module: pixel_config_array
// PURPOSE
// - Multi-channel successor to the single-chain pixel configurator: buffers per-pixel config words written from SRAM.
// - On start, shifts the words into N_CH parallel pixel chains through one shared divided serial clock.
// - Finishes each run with a latch strobe. Sits between the SRAM/register bus and the chip's config pads.
// PARAMETERS
// - DIV_WIDTH       6   width of DIV; S_CLK half-period = 2**DIV SYS_CLK cycles
// - DATA_WIDTH      15  bits per pixel config word per channel
// - N_CH            2   number of parallel serial chains (S_DATA lanes)
// - ADDR_WIDTH      5   buffer depth = 2**ADDR_WIDTH entries
// - SHIFT_DIRECTION 1   1: MSB shifted first; 0: LSB first
// PORTS
// - SYS_CLK      in   1                 system clock, all logic on rising edge
// - RESET_N      in   1                 asynchronous active-low reset
// - DIV          in   DIV_WIDTH         clock divide exponent, sampled at pulse_start
// - SRAM_DATA    in   N_CH*DATA_WIDTH   entry data; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]
// - SRAM_WE      in   1                 write one entry at the write pointer
// - pulse_start  in   1                 1-cycle start request
// - BUSY         in   1                 downstream hold-off; pauses between entries
// - S_CLK        out  1                 shared serial clock to pixel chains
// - S_DATA       out  N_CH              serial data lanes
// - S_LOAD       out  1                 latch strobe after the last entry
// - RUNNING      out  1                 high from the cycle after accepted start until DONE
// - DONE         out  1                 1-cycle pulse at end of run
// - FULL         out  1                 buffer holds 2**ADDR_WIDTH entries
// - COUNT        out  ADDR_WIDTH+1      number of stored entries
// - ERR          out  1                 sticky: write while RUNNING or FULL; cleared by an accepted pulse_start
// BEHAVIOUR
// - Reset: all outputs 0; COUNT=0; state IDLE; buffer contents undefined.
// - Writes: in IDLE with !FULL, SRAM_WE stores the entry and COUNT increments next cycle.
//   - SRAM_WE while FULL or RUNNING: data dropped, ERR set.
// - Start: pulse_start accepted only in IDLE. Ignored while RUNNING; a simultaneous SRAM_WE is dropped and sets ERR.
//   - DIV is latched at acceptance; the divider counter is cleared.
// - Accepted with COUNT=0: DONE pulses the next cycle; no S_CLK or S_LOAD activity.
// - States: IDLE -> SHIFT -> (PAUSE) -> LOAD -> FINISH -> IDLE.
// - SHIFT:
//   - The cycle after acceptance: RUNNING=1, S_CLK=0, S_DATA = first bit of entry 0 on every lane.
//   - A tick occurs every 2**DIV cycles and toggles S_CLK.
//   - On each falling toggle, S_DATA advances to the next bit. Data is stable across each rising edge.
//   - An entry takes exactly DATA_WIDTH S_CLK rising edges; entries are sent in write order, 0 upward.
// - Entry boundary, after the falling edge ending an entry:
//   - If BUSY=1 and entries remain: enter PAUSE, S_CLK held 0, S_DATA holds the next entry's first bit.
//   - Leave PAUSE the cycle after BUSY=0, with the divider restarted.
// - LOAD (after the last entry's final falling edge): S_CLK=0, S_LOAD=1 for exactly 2**(DIV+1) cycles. BUSY is ignored.
// - FINISH: DONE=1 for one cycle, RUNNING falls the same cycle; COUNT cleared to 0.
// - Run length: COUNT*DATA_WIDTH*2**(DIV+1) + 2**(DIV+1) + 2 cycles, excluding PAUSE.
// - RESET_N low mid-run: S_CLK, S_DATA and S_LOAD go to 0 immediately; COUNT=0; the partial run is abandoned.
// - Counters wrap only via COUNT clear; the read pointer never passes COUNT.
// CONFIGURATION
// - PIXEL_CFG_REPLAY_EN defined:
//   - FINISH does not clear COUNT; the buffer is retained, so a later pulse_start replays identical data.
//   - An SRAM_WE in IDLE after a completed run first clears COUNT, then stores at entry 0.
// - PIXEL_CFG_REPLAY_EN undefined: COUNT is cleared in FINISH (baseline above).
// TESTING
// - Basic run (DIV=2, N_CH=2, DATA_WIDTH=15, SHIFT_DIRECTION=1):
//   - Stimulus: write lanes {15'h4001,15'h2001}, {15'h4002,15'h2002}, {15'h4003,15'h2003}; pulse_start.
//   - Response: 45 S_CLK rising edges, period 8 cycles; MSB-first bits match per lane.
//   - Then S_LOAD high for 8 cycles, one DONE pulse, COUNT=0.
// - BUSY pause: raise BUSY=1 during entry 0 and hold 200 cycles.
//   - S_CLK stays low after bit 15 of entry 0 until BUSY falls; the entry 1 bit stream is then intact.
// - Overflow: with ADDR_WIDTH=2, do 5 writes.
//   - FULL=1 after 4 writes, COUNT=4, ERR=1; the 5th word is never shifted out.
// - Empty start and busy start:
//   - pulse_start with COUNT=0 -> DONE the next cycle, S_CLK never toggles.
//   - pulse_start during a run -> ignored, with a single DONE at the end.
// - Reset mid-run: RESET_N=0 at the 20th S_CLK edge.
//   - Outputs 0 asynchronously, COUNT=0; a new 1-entry run afterwards is correct.
// - Replay (PIXEL_CFG_REPLAY_EN): two pulse_starts after one 3-entry load -> identical S_DATA traces.
//   - A following write -> COUNT=1.

Source files
------------

// File: rtl/pixel_config_array.sv
// Buffers N_CH-lane pixel config words and shifts them into parallel pixel chains
// on one shared divided serial clock. Define PIXEL_CFG_REPLAY_EN to retain the buffer for replay.
module pixel_config_array #(
    parameter int DIV_WIDTH       = 6,
    parameter int DATA_WIDTH      = 15,
    parameter int N_CH            = 2,
    parameter int ADDR_WIDTH      = 5,
    parameter int SHIFT_DIRECTION = 1
) (
    input  logic                         SYS_CLK,
    input  logic                         RESET_N,
    input  logic [DIV_WIDTH-1:0]         DIV,
    input  logic [N_CH*DATA_WIDTH-1:0]   SRAM_DATA,
    input  logic                         SRAM_WE,
    input  logic                         pulse_start,
    input  logic                         BUSY,
    output logic                         S_CLK,
    output logic [N_CH-1:0]              S_DATA,
    output logic                         S_LOAD,
    output logic                         RUNNING,
    output logic                         DONE,
    output logic                         FULL,
    output logic [ADDR_WIDTH:0]          COUNT,
    output logic                         ERR
);

    localparam int DEPTH    = 2**ADDR_WIDTH;
    localparam int CNT_BITS = ADDR_WIDTH + 1;
    // One spare bit so the LOAD span of 2**(DIV+1) cycles fits for the largest DIV
    localparam int CNT_W    = 2**DIV_WIDTH + 1;
    localparam int BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        PAUSE,
        LOAD,
        FINISH
    } state_t;

    state_t                       state, state_nxt;
    logic [N_CH*DATA_WIDTH-1:0]   mem [DEPTH];
    logic [N_CH*DATA_WIDTH-1:0]   cur_word;
    logic [DIV_WIDTH-1:0]         div_q;
    logic [CNT_W-1:0]             div_cnt;
    logic [CNT_W-1:0]             half_mask;
    logic [CNT_W-1:0]             load_mask;
    logic [BIT_W-1:0]             bit_idx;
    logic [BIT_W-1:0]             bit_pos;
    logic [ADDR_WIDTH-1:0]        rd_ptr;
    logic [ADDR_WIDTH-1:0]        wr_addr;
    logic [CNT_BITS-1:0]          count_q;
    logic [CNT_BITS-1:0]          wr_base;
    logic [N_CH-1:0]              lane_bits;
    logic                         s_clk_q;
    logic                         err_q;
    logic                         tick;
    logic                         load_end;
    logic                         last_bit;
    logic                         last_entry;
    logic                         entry_end;
    logic                         start_ok;
    logic                         wr_ok;
    logic                         wr_drop;
    logic                         full_int;
`ifdef PIXEL_CFG_REPLAY_EN
    logic                         replay_pend;
`endif

    always_comb begin
        half_mask  = ~({CNT_W{1'b1}} << div_q);
        load_mask  = {half_mask[CNT_W-2:0], 1'b1};
        tick       = (div_cnt == half_mask);
        load_end   = (div_cnt == load_mask);
        last_bit   = (bit_idx == BIT_W'(DATA_WIDTH - 1));
        last_entry = ({1'b0, rd_ptr} == (count_q - 1'b1));
        entry_end  = (state == SHIFT) && tick && s_clk_q && last_bit;
        full_int   = (count_q == CNT_BITS'(DEPTH));
        start_ok   = (state == IDLE) && pulse_start;
        bit_pos    = (SHIFT_DIRECTION != 0) ? (BIT_W'(DATA_WIDTH - 1) - bit_idx) : bit_idx;
        cur_word   = mem[rd_ptr];
    end

    // A write after a completed run restarts the buffer at entry 0 when replay is enabled
    always_comb begin
`ifdef PIXEL_CFG_REPLAY_EN
        wr_base = replay_pend ? '0 : count_q;
        wr_ok   = SRAM_WE && (state == IDLE) && !pulse_start && (!full_int || replay_pend);
`else
        wr_base = count_q;
        wr_ok   = SRAM_WE && (state == IDLE) && !pulse_start && !full_int;
`endif
        wr_drop = SRAM_WE && !wr_ok;
        wr_addr = wr_base[ADDR_WIDTH-1:0];
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_word;
        assign lane_word    = cur_word[k*DATA_WIDTH +: DATA_WIDTH];
        assign lane_bits[k] = lane_word[bit_pos];
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        RUNNING   = 1'b0;
        DONE      = 1'b0;
        S_LOAD    = 1'b0;
        S_DATA    = '0;
        case (state)
            IDLE: begin
                if (pulse_start) begin
                    state_nxt = (count_q == '0) ? FINISH : SHIFT;
                end
            end
            SHIFT: begin
                RUNNING = 1'b1;
                S_DATA  = lane_bits;
                if (entry_end) begin
                    if (last_entry) begin
                        state_nxt = LOAD;
                    end else if (BUSY) begin
                        state_nxt = PAUSE;
                    end
                end
            end
            PAUSE: begin
                RUNNING = 1'b1;
                S_DATA  = lane_bits;
                if (!BUSY) begin
                    state_nxt = SHIFT;
                end
            end
            LOAD: begin
                RUNNING = 1'b1;
                S_LOAD  = 1'b1;
                if (load_end) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                DONE      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial clock divider, bit and entry sequencing
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q   <= '0;
            div_cnt <= '0;
            bit_idx <= '0;
            rd_ptr  <= '0;
            s_clk_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pulse_start) begin
                        div_q   <= DIV;
                        div_cnt <= '0;
                        bit_idx <= '0;
                        rd_ptr  <= '0;
                        s_clk_q <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        div_cnt <= '0;
                        s_clk_q <= ~s_clk_q;
                        if (s_clk_q) begin
                            if (last_bit) begin
                                bit_idx <= '0;
                                if (!last_entry) begin
                                    rd_ptr <= rd_ptr + 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                PAUSE: begin
                    div_cnt <= '0;
                end
                LOAD: begin
                    div_cnt <= div_cnt + 1'b1;
                end
                default: begin
                    div_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (wr_ok) begin
            mem[wr_addr] <= SRAM_DATA;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                count_q <= wr_base + 1'b1;
            end
`ifndef PIXEL_CFG_REPLAY_EN
            else if (state == FINISH) begin
                count_q <= '0;
            end
`endif
            if (wr_drop) begin
                err_q <= 1'b1;
            end else if (start_ok) begin
                err_q <= 1'b0;
            end
        end
    end

`ifdef PIXEL_CFG_REPLAY_EN
    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            replay_pend <= 1'b0;
        end else if (state == FINISH) begin
            replay_pend <= 1'b1;
        end else if (wr_ok) begin
            replay_pend <= 1'b0;
        end
    end
`endif

    always_comb begin
        S_CLK = s_clk_q;
        FULL  = full_int;
        COUNT = count_q;
        ERR   = err_q;
    end

endmodule

// File: tb/tb_pixel_config_array.sv
// Directed bench for pixel_config_array: a scoreboard queue holds the expected S_DATA
// lane bits for every S_CLK rising edge, filled when a run is started.
module tb_pixel_config_array;

    localparam int DW    = 15;
    localparam int NC    = 2;
    localparam int AW    = 2;
    localparam int DVW   = 6;
    localparam int DIVV  = 2;
    localparam int BITP  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DVW-1:0]    div = '0;
    logic [NC*DW-1:0]  sram_data = '0;
    logic              sram_we = 1'b0;
    logic              pulse_start = 1'b0;
    logic              busy = 1'b0;
    logic              s_clk;
    logic [NC-1:0]     s_data;
    logic              s_load;
    logic              running;
    logic              done;
    logic              full;
    logic [AW:0]       count;
    logic              err;

    pixel_config_array #(
        .DIV_WIDTH(DVW),
        .DATA_WIDTH(DW),
        .N_CH(NC),
        .ADDR_WIDTH(AW),
        .SHIFT_DIRECTION(1)
    ) dut (
        .SYS_CLK(clk),
        .RESET_N(rst_n),
        .DIV(div),
        .SRAM_DATA(sram_data),
        .SRAM_WE(sram_we),
        .pulse_start(pulse_start),
        .BUSY(busy),
        .S_CLK(s_clk),
        .S_DATA(s_data),
        .S_LOAD(s_load),
        .RUNNING(running),
        .DONE(done),
        .FULL(full),
        .COUNT(count),
        .ERR(err)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              failures = 0;
    logic [NC-1:0]   exp_q[$];
    logic [NC*DW-1:0] model_mem[$];
    bit              model_pend = 1'b0;
    int              rise_cnt = 0;
    int              load_cyc = 0;
    int              done_cnt = 0;
    logic            sclk_prev = 1'b0;
    int              run_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (s_clk && !sclk_prev) begin
                rise_cnt++;
                chk("rise_has_expect", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("s_data_bit", s_data, exp_q.pop_front());
                end
            end
            if (s_load) begin
                load_cyc++;
                chk("s_clk_low_in_load", s_clk, 0);
            end
            if (done) begin
                done_cnt++;
            end
        end
        sclk_prev = s_clk;
    end

    task automatic write_word(input logic [NC*DW-1:0] w);
        @(negedge clk);
        sram_data = w;
        sram_we   = 1'b1;
        if (model_pend) begin
            model_mem.delete();
            model_pend = 1'b0;
        end
        if (model_mem.size() < 2**AW) begin
            model_mem.push_back(w);
        end
        @(negedge clk);
        sram_we = 1'b0;
    endtask

    task automatic start_run();
        foreach (model_mem[e]) begin
            for (int i = DW - 1; i >= 0; i--) begin
                logic [NC-1:0] b;
                for (int k = 0; k < NC; k++) begin
                    b[k] = model_mem[e][k*DW + i];
                end
                exp_q.push_back(b);
            end
        end
        @(negedge clk);
        pulse_start = 1'b1;
        @(negedge clk);
        pulse_start = 1'b0;
        run_cyc = 1;
    endtask

    task automatic wait_done(input int limit);
        while (!done && run_cyc < limit) begin
            @(negedge clk);
            run_cyc++;
        end
        chk("done_seen", done, 1);
        chk("running_low_at_done", running, 0);
        @(negedge clk);
`ifdef PIXEL_CFG_REPLAY_EN
        model_pend = 1'b1;
`else
        model_mem.delete();
`endif
    endtask

    task automatic wait_rises(input int target, input int limit);
        int n = 0;
        while (rise_cnt < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rise_wait", rise_cnt >= target, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int d0;
        int l0;
        div = DIVV;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_clk", s_clk, 0);
        chk("rst_s_data", s_data, 0);
        chk("rst_s_load", s_load, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty start
        r0 = rise_cnt;
        d0 = done_cnt;
        start_run();
        chk("empty_running", running, 0);
        wait_done(100);
        chk("empty_done_latency", run_cyc, 1);
        chk("empty_no_sclk", rise_cnt - r0, 0);
        chk("empty_done_count", done_cnt - d0, 1);

        // Basic 3-entry run
        write_word({15'h4001, 15'h2001});
        write_word({15'h4002, 15'h2002});
        write_word({15'h4003, 15'h2003});
        chk("basic_count", count, 3);
        chk("basic_full", full, 0);
        r0 = rise_cnt;
        d0 = done_cnt;
        l0 = load_cyc;
        start_run();
        chk("basic_running", running, 1);
        chk("basic_sclk_low", s_clk, 0);
        chk("basic_first_bit", s_data, exp_q[0]);
        wait_done(5000);
        chk("basic_run_cycles", run_cyc, 3*DW*BITP + BITP + 1);
        chk("basic_rises", rise_cnt - r0, 3*DW);
        chk("basic_load_cycles", load_cyc - l0, BITP);
        chk("basic_done_count", done_cnt - d0, 1);
        chk("basic_queue_drained", exp_q.size(), 0);
        chk("basic_count_after", count, model_mem.size());

        // BUSY pause at the entry 0 / entry 1 boundary
        write_word({15'h1234, 15'h6DB6});
        write_word({15'h7001, 15'h0ABC});
        r0 = rise_cnt;
        start_run();
        wait_rises(r0 + 5, 2000);
        busy = 1'b1;
        repeat (200) @(negedge clk);
        #1;
        chk("pause_rises", rise_cnt - r0, DW);
        chk("pause_sclk_low", s_clk, 0);
        chk("pause_running", running, 1);
        chk("pause_next_first_bit", s_data, exp_q[0]);
        busy = 1'b0;
        wait_done(5000);
        chk("pause_total_rises", rise_cnt - r0, 2*DW);
        chk("pause_queue_drained", exp_q.size(), 0);

        // Overflow, then a start request and a write during the run
        for (int w = 0; w < 4; w++) begin
            write_word({15'(32'h0100 + w), 15'(32'h7F00 - w)});
        end
        chk("ovf_full", full, 1);
        chk("ovf_count4", count, 4);
        chk("ovf_err_clear", err, 0);
        write_word({15'h7FFF, 15'h7FFF});
        chk("ovf_err", err, 1);
        chk("ovf_count_hold", count, 4);
        r0 = rise_cnt;
        d0 = done_cnt;
        start_run();
        chk("ovf_err_cleared_by_start", err, 0);
        repeat (50) @(negedge clk);
        pulse_start = 1'b1;
        sram_we     = 1'b1;
        sram_data   = '0;
        @(negedge clk);
        pulse_start = 1'b0;
        sram_we     = 1'b0;
        chk("busy_start_err", err, 1);
        chk("busy_start_count", count, 4);
        chk("busy_start_running", running, 1);
        wait_done(20000);
        repeat (20) @(negedge clk);
        chk("busy_start_single_done", done_cnt - d0, 1);
        chk("ovf_rises", rise_cnt - r0, 4*DW);
        chk("ovf_queue_drained", exp_q.size(), 0);

        // Reset in the middle of a run
        write_word({15'h0F0F, 15'h70F0});
        write_word({15'h3333, 15'h4CCC});
        r0 = rise_cnt;
        start_run();
        wait_rises(r0 + 20, 4000);
        chk("pre_reset_sclk_high", s_clk, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_s_clk", s_clk, 0);
        chk("midrst_s_data", s_data, 0);
        chk("midrst_s_load", s_load, 0);
        chk("midrst_count", count, 0);
        chk("midrst_running", running, 0);
        exp_q.delete();
        model_mem.delete();
        model_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        write_word({15'h2AAA, 15'h5555});
        r0 = rise_cnt;
        d0 = done_cnt;
        start_run();
        chk("post_rst_first_bit", s_data, exp_q[0]);
        wait_done(5000);
        chk("post_rst_cycles", run_cyc, DW*BITP + BITP + 1);
        chk("post_rst_rises", rise_cnt - r0, DW);
        chk("post_rst_done_count", done_cnt - d0, 1);
        chk("post_rst_queue", exp_q.size(), 0);
        chk("post_rst_count", count, model_mem.size());

`ifdef PIXEL_CFG_REPLAY_EN
        // Replay: same buffer shifted twice, then a write restarts at entry 0
        write_word({15'h5001, 15'h0123});
        write_word({15'h6002, 15'h4567});
        write_word({15'h7003, 15'h0089});
        chk("replay_count", count, 3);
        r0 = rise_cnt;
        start_run();
        wait_done(5000);
        start_run();
        wait_done(5000);
        chk("replay_rises", rise_cnt - r0, 6*DW);
        chk("replay_queue_drained", exp_q.size(), 0);
        chk("replay_count_kept", count, 3);
        write_word({15'h1111, 15'h2222});
        chk("replay_write_count", count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
